// File: rtl/store_retire_buffer_pkg.sv
// Load/store unit shared types for the post-commit store retire buffer.
//   - Address/data path typedefs for a 4-byte block.
//   - StoreRetireBufferEntry record: block address, byte enables, data.
//   - STORE_RETIRE_BUFFER_ENTRY_NUM: default buffer depth.
//   - LSQ_ToFullAddrFromBlockAddr: block address -> byte address.
package LoadStoreUnitTypes;

    localparam int PHY_ADDR_WIDTH           = 32;
    localparam int LSQ_BLOCK_BYTE_NUM       = 4;
    localparam int LSQ_BLOCK_BYTE_NUM_BITS  = $clog2(LSQ_BLOCK_BYTE_NUM);
    localparam int LSQ_BLOCK_DATA_WIDTH     = LSQ_BLOCK_BYTE_NUM * 8;
    localparam int LSQ_BLOCK_ADDR_WIDTH     = PHY_ADDR_WIDTH - LSQ_BLOCK_BYTE_NUM_BITS;

    localparam int STORE_RETIRE_BUFFER_ENTRY_NUM = 4;

    typedef logic [PHY_ADDR_WIDTH-1:0]       PhyAddrPath;
    typedef logic [LSQ_BLOCK_ADDR_WIDTH-1:0] LSQ_BlockAddrPath;
    typedef logic [LSQ_BLOCK_BYTE_NUM-1:0]   LSQ_WordByteEnablePath;
    typedef logic [LSQ_BLOCK_DATA_WIDTH-1:0] LSQ_BlockDataPath;

    typedef struct packed {
        LSQ_BlockAddrPath      addr;
        LSQ_WordByteEnablePath byteWE;
        LSQ_BlockDataPath      data;
    } StoreRetireBufferEntry;

    // Block addresses index whole blocks; append zero byte-offset bits.
    function automatic PhyAddrPath LSQ_ToFullAddrFromBlockAddr(input LSQ_BlockAddrPath a);
        return {a, {LSQ_BLOCK_BYTE_NUM_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/store_retire_buffer_forwarder.sv
// Byte-granular store-to-load forwarding over the retire buffer contents.
// Ports:
//   entries_i   : buffer storage array
//   valid_i     : per-slot valid bits
//   head_i      : oldest slot index; age increases from head towards tail
//   probe_addr_i: load block address
//   probe_re_i  : load byte read enables
//   data_o      : forwarded bytes, zero where no store covers the byte
//   hit_o       : every requested byte covered
//   conflict_o  : some but not all requested bytes covered
module store_retire_buffer_forwarder
    import LoadStoreUnitTypes::*;
#(
    parameter int ENTRY_NUM = STORE_RETIRE_BUFFER_ENTRY_NUM,
    parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
    input  StoreRetireBufferEntry entries_i [ENTRY_NUM],
    input  logic [ENTRY_NUM-1:0]  valid_i,
    input  logic [PTR_W-1:0]      head_i,
    input  LSQ_BlockAddrPath      probe_addr_i,
    input  LSQ_WordByteEnablePath probe_re_i,
    output LSQ_BlockDataPath      data_o,
    output logic                  hit_o,
    output logic                  conflict_o
);

    LSQ_WordByteEnablePath covered;
    logic [PTR_W-1:0]      idx;

    // Walk slots oldest to youngest starting at head; a later (younger)
    // match overwrites an earlier one, so the youngest store wins per byte.
    always_comb begin
        data_o  = '0;
        covered = '0;
        idx     = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            idx = head_i + k[PTR_W-1:0];
            if (valid_i[idx] && entries_i[idx].addr == probe_addr_i) begin
                for (int b = 0; b < LSQ_BLOCK_BYTE_NUM; b++) begin
                    if (entries_i[idx].byteWE[b]) begin
                        covered[b]       = 1'b1;
                        data_o[b*8 +: 8] = entries_i[idx].data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign hit_o      = (probe_re_i != '0) && ((probe_re_i & ~covered) == '0);
    assign conflict_o = ((probe_re_i & covered) != '0) && !hit_o;

endmodule

// File: rtl/store_retire_buffer.sv
// Post-commit store retire buffer: in-order FIFO of committed stores that
// drains to the D-cache write port and forwards data to younger loads.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   commitValid/Ready/Addr/ByteWE/Data : enqueue of committed stores
//   dcWrReq/Ack/Addr/Data/ByteWE       : head drain to the D-cache
//   probeAddr/ByteRE -> probeHit/Conflict/Data : combinational forwarding
//   empty, count             : occupancy (registered-derived)
module store_retire_buffer
    import LoadStoreUnitTypes::*;
#(
    parameter int ENTRY_NUM = STORE_RETIRE_BUFFER_ENTRY_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           commitValid,
    output logic                           commitReady,
    input  LSQ_BlockAddrPath               commitAddr,
    input  LSQ_WordByteEnablePath          commitByteWE,
    input  LSQ_BlockDataPath               commitData,
    output logic                           dcWrReq,
    input  logic                           dcWrAck,
    output PhyAddrPath                     dcWrAddr,
    output LSQ_BlockDataPath               dcWrData,
    output LSQ_WordByteEnablePath          dcWrByteWE,
    input  LSQ_BlockAddrPath               probeAddr,
    input  LSQ_WordByteEnablePath          probeByteRE,
    output logic                           probeHit,
    output logic                           probeConflict,
    output LSQ_BlockDataPath               probeData,
    output logic                           empty,
    output logic [$clog2(ENTRY_NUM):0]     count
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;

    StoreRetireBufferEntry entries_q [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic enq, deq;

    // Ready looks only at registered count: no ack-to-ready bypass.
    assign commitReady = (count_q != CNT_W'(ENTRY_NUM));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign dcWrReq     = !empty;

    assign enq = commitValid && commitReady;
    assign deq = dcWrAck && dcWrReq;

    // Head fields are forced to zero while empty so a stale slot never shows.
    assign dcWrAddr   = dcWrReq ? LSQ_ToFullAddrFromBlockAddr(entries_q[head_q].addr) : '0;
    assign dcWrData   = dcWrReq ? entries_q[head_q].data   : '0;
    assign dcWrByteWE = dcWrReq ? entries_q[head_q].byteWE : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (deq) begin
            head_d          = head_q + PTR_W'(1);
            valid_d[head_q] = 1'b0;
        end
        if (enq) begin
            tail_d          = tail_q + PTR_W'(1);
            valid_d[tail_q] = 1'b1;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            if (enq) begin
                entries_q[tail_q].addr   <= commitAddr;
                entries_q[tail_q].byteWE <= commitByteWE;
                entries_q[tail_q].data   <= commitData;
            end
        end
    end

    store_retire_buffer_forwarder #(
        .ENTRY_NUM (ENTRY_NUM),
        .PTR_W     (PTR_W)
    ) u_fwd (
        .entries_i    (entries_q),
        .valid_i      (valid_q),
        .head_i       (head_q),
        .probe_addr_i (probeAddr),
        .probe_re_i   (probeByteRE),
        .data_o       (probeData),
        .hit_o        (probeHit),
        .conflict_o   (probeConflict)
    );

endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed self-checking bench for store_retire_buffer (ENTRY_NUM = 4).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_store_retire_buffer;
    import LoadStoreUnitTypes::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  commitValid;
    logic                  commitReady;
    LSQ_BlockAddrPath      commitAddr;
    LSQ_WordByteEnablePath commitByteWE;
    LSQ_BlockDataPath      commitData;
    logic                  dcWrReq;
    logic                  dcWrAck;
    PhyAddrPath            dcWrAddr;
    LSQ_BlockDataPath      dcWrData;
    LSQ_WordByteEnablePath dcWrByteWE;
    LSQ_BlockAddrPath      probeAddr;
    LSQ_WordByteEnablePath probeByteRE;
    logic                  probeHit;
    logic                  probeConflict;
    LSQ_BlockDataPath      probeData;
    logic                  empty;
    logic [2:0]            count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_retire_buffer #(.ENTRY_NUM(4)) dut (
        .clk(clk), .rst(rst),
        .commitValid(commitValid), .commitReady(commitReady),
        .commitAddr(commitAddr), .commitByteWE(commitByteWE), .commitData(commitData),
        .dcWrReq(dcWrReq), .dcWrAck(dcWrAck), .dcWrAddr(dcWrAddr),
        .dcWrData(dcWrData), .dcWrByteWE(dcWrByteWE),
        .probeAddr(probeAddr), .probeByteRE(probeByteRE),
        .probeHit(probeHit), .probeConflict(probeConflict), .probeData(probeData),
        .empty(empty), .count(count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_commit(input logic v, input LSQ_BlockAddrPath a,
                                input LSQ_WordByteEnablePath we, input LSQ_BlockDataPath d);
        commitValid  = v;
        commitAddr   = a;
        commitByteWE = we;
        commitData   = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_commit(1'b0, '0, '0, '0);
        dcWrAck = 1'b0; probeAddr = '0; probeByteRE = 4'b1111;
        step(); step();
        n_cmp++; if (commitReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", commitReady); end
        n_cmp++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL rst_occ got empty=%b count=%0d want 1/0", empty, count); end
        n_cmp++; if (dcWrReq !== 1'b0 || dcWrAddr !== 32'h0 || dcWrData !== 32'h0 || dcWrByteWE !== 4'h0)
            begin n_fail++; $display("FAIL rst_dc got req=%b a=%h d=%h we=%h want all 0", dcWrReq, dcWrAddr, dcWrData, dcWrByteWE); end
        n_cmp++; if (probeHit !== 1'b0 || probeConflict !== 1'b0 || probeData !== 32'h0)
            begin n_fail++; $display("FAIL rst_probe got h=%b c=%b d=%h want 0/0/0", probeHit, probeConflict, probeData); end
        rst = 1'b0;
        step();
        // Ack with no request must be ignored (no underflow).
        dcWrAck = 1'b1;
        step();
        dcWrAck = 1'b0;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL stray_ack got count=%0d empty=%b want 0/1", count, empty); end
    endtask

    task automatic test_single_store();
        drive_commit(1'b1, 30'h100, 4'b1111, 32'hDEADBEEF);
        step();                               // t: captured
        drive_commit(1'b0, '0, '0, '0);
        for (int c = 1; c <= 3; c++) begin    // t+1..t+3: fields stable
            if (c == 3) dcWrAck = 1'b1;
            n_cmp++; if (dcWrReq !== 1'b1 || dcWrAddr !== 32'h400 || dcWrData !== 32'hDEADBEEF || dcWrByteWE !== 4'b1111)
                begin n_fail++; $display("FAIL single_head_c%0d got req=%b a=%h d=%h we=%b want 1/400/deadbeef/1111", c, dcWrReq, dcWrAddr, dcWrData, dcWrByteWE); end
            step();
        end
        dcWrAck = 1'b0;
        n_cmp++; if (empty !== 1'b1 || dcWrReq !== 1'b0) begin n_fail++; $display("FAIL single_drained got empty=%b req=%b want 1/0", empty, dcWrReq); end
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= 4; i++) begin
            drive_commit(1'b1, 30'h200 + 30'(i), 4'b1111, 32'hA000_0000 + 32'(i));
            step();
        end
        n_cmp++; if (commitReady !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_ready got rdy=%b count=%0d want 0/4", commitReady, count); end
        drive_commit(1'b1, 30'h205, 4'b1111, 32'hA000_0005);
        step();                               // 5th held
        n_cmp++; if (count !== 3'd4 || commitReady !== 1'b0) begin n_fail++; $display("FAIL full_hold got count=%0d rdy=%b want 4/0", count, commitReady); end
        dcWrAck = 1'b1;
        step();                               // retire #1, 5th still blocked this edge
        dcWrAck = 1'b0;
        n_cmp++; if (commitReady !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL full_reopen got rdy=%b count=%0d want 1/3", commitReady, count); end
        step();                               // 5th enqueues into wrapped slot
        drive_commit(1'b0, '0, '0, '0);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_5th got count=%0d want 4", count); end
        dcWrAck = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            n_cmp++; if (dcWrData !== 32'hA000_0000 + 32'(i) || dcWrAddr !== 32'h800 + 32'(i*4))
                begin n_fail++; $display("FAIL drain_order_%0d got d=%h a=%h want %h/%h", i, dcWrData, dcWrAddr, 32'hA000_0000 + 32'(i), 32'h800 + 32'(i*4)); end
            step();
        end
        dcWrAck = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained got empty=%b want 1", empty); end
    endtask

    task automatic test_forward_youngest();
        drive_commit(1'b1, 30'h10, 4'b1111, 32'h11223344); step();
        drive_commit(1'b1, 30'h10, 4'b0011, 32'h0000AABB); step();
        drive_commit(1'b0, '0, '0, '0);
        probeAddr = 30'h10; probeByteRE = 4'b1111; #1;
        n_cmp++; if (probeHit !== 1'b1 || probeConflict !== 1'b0 || probeData !== 32'h1122AABB)
            begin n_fail++; $display("FAIL fwd_young got h=%b c=%b d=%h want 1/0/1122aabb", probeHit, probeConflict, probeData); end
        dcWrAck = 1'b1; step(); step(); dcWrAck = 1'b0;
        n_cmp++; if (probeHit !== 1'b0 || probeData !== 32'h0) begin n_fail++; $display("FAIL fwd_after_drain got h=%b d=%h want 0/0", probeHit, probeData); end
    endtask

    task automatic test_partial();
        drive_commit(1'b1, 30'h20, 4'b0001, 32'h000000CC); step();
        drive_commit(1'b0, '0, '0, '0);
        probeAddr = 30'h20; probeByteRE = 4'b0011; #1;
        n_cmp++; if (probeHit !== 1'b0 || probeConflict !== 1'b1 || probeData !== 32'h000000CC)
            begin n_fail++; $display("FAIL partial got h=%b c=%b d=%h want 0/1/000000cc", probeHit, probeConflict, probeData); end
        probeAddr = 30'h21; #1;
        n_cmp++; if (probeHit !== 1'b0 || probeConflict !== 1'b0 || probeData !== 32'h0)
            begin n_fail++; $display("FAIL partial_miss got h=%b c=%b d=%h want 0/0/0", probeHit, probeConflict, probeData); end
        probeAddr = 30'h20; probeByteRE = 4'b0000; #1;
        n_cmp++; if (probeHit !== 1'b0 || probeConflict !== 1'b0)
            begin n_fail++; $display("FAIL partial_re0 got h=%b c=%b want 0/0", probeHit, probeConflict); end
        dcWrAck = 1'b1; step(); dcWrAck = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_commit(1'b1, 30'h30, 4'b1111, 32'h30303030); step();
        drive_commit(1'b1, 30'h31, 4'b1111, 32'h31313131); step();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_pre got count=%0d want 2", count); end
        drive_commit(1'b1, 30'h32, 4'b1111, 32'h32323232);
        dcWrAck = 1'b1;
        step();                               // enqueue 0x32 and retire 0x30 together
        drive_commit(1'b0, '0, '0, '0);
        dcWrAck = 1'b0;
        n_cmp++; if (count !== 3'd2 || dcWrAddr !== 32'hC4) begin n_fail++; $display("FAIL b2b_same got count=%0d a=%h want 2/c4", count, dcWrAddr); end
        probeAddr = 30'h30; probeByteRE = 4'b1111; #1;
        n_cmp++; if (probeHit !== 1'b0 || probeConflict !== 1'b0) begin n_fail++; $display("FAIL b2b_acked_probe got h=%b c=%b want 0/0", probeHit, probeConflict); end
        dcWrAck = 1'b1;
        n_cmp++; if (dcWrData !== 32'h31313131) begin n_fail++; $display("FAIL b2b_ord0 got %h want 31313131", dcWrData); end
        step();
        n_cmp++; if (dcWrData !== 32'h32323232) begin n_fail++; $display("FAIL b2b_ord1 got %h want 32323232", dcWrData); end
        step();
        dcWrAck = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drained got empty=%b want 1", empty); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive_commit(1'b1, 30'h40 + 30'(i), 4'b1111, 32'h4000_0000 + 32'(i));
            step();
        end
        drive_commit(1'b0, '0, '0, '0);
        probeAddr = 30'h41; probeByteRE = 4'b1111; #1;
        n_cmp++; if (count !== 3'd3 || dcWrReq !== 1'b1 || probeHit !== 1'b1)
            begin n_fail++; $display("FAIL arst_pre got count=%0d req=%b h=%b want 3/1/1", count, dcWrReq, probeHit); end
        #2 rst = 1'b1;                        // mid-cycle, away from any edge
        #1;
        n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || commitReady !== 1'b1 || dcWrReq !== 1'b0 ||
                     dcWrAddr !== 32'h0 || dcWrData !== 32'h0 || dcWrByteWE !== 4'h0 ||
                     probeHit !== 1'b0 || probeConflict !== 1'b0 || probeData !== 32'h0)
            begin n_fail++; $display("FAIL arst_now got cnt=%0d e=%b r=%b req=%b a=%h d=%h we=%h h=%b c=%b pd=%h want reset values",
                                     count, empty, commitReady, dcWrReq, dcWrAddr, dcWrData, dcWrByteWE, probeHit, probeConflict, probeData); end
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (dcWrReq !== 1'b0) begin n_fail++; $display("FAIL arst_post_%0d got req=%b want 0", c, dcWrReq); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_store();
        test_fill_full();
        test_forward_youngest();
        test_partial();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
